// File: rtl/hd44780_timer_bank.sv
// Bank of independent countdown timers sharing one load bus. Each channel
// emits a registered one-cycle expiry pulse, once or with auto-reload.
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 23
`endif

module hd44780_timer_bank #(
  parameter int CHANNELS   = 4,
  parameter int TIMER_BITS = `H4_TIMER_BITS
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [TIMER_BITS-1:0] DAT_I,
  input  logic [CHANNELS-1:0]   start_strobe,
  input  logic [CHANNELS-1:0]   periodic,
  input  logic [CHANNELS-1:0]   stop_strobe,
  output logic [CHANNELS-1:0]   end_strobe,
  output logic [CHANNELS-1:0]   busy
);

  localparam logic [TIMER_BITS-1:0] ONE = TIMER_BITS'(1);

  // A zero load would never expire, so it is promoted to the shortest delay.
  logic [TIMER_BITS-1:0] load_val;
  assign load_val = (DAT_I == '0) ? ONE : DAT_I;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [TIMER_BITS-1:0] count_reg, count_next;
      logic [TIMER_BITS-1:0] reload_reg, reload_next;
      logic                  mode_reg, mode_next;
      logic                  busy_reg, busy_next;
      logic                  end_reg, end_next;

      always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        busy_next   = busy_reg;
        end_next    = 1'b0;
        // Start takes priority over stop and over any expiry on this edge.
        if (start_strobe[gi]) begin
          count_next  = load_val;
          reload_next = load_val;
          mode_next   = periodic[gi];
          busy_next   = 1'b1;
        end else if (stop_strobe[gi]) begin
          count_next = '0;
          busy_next  = 1'b0;
        end else if (busy_reg) begin
          if (count_reg != ONE) begin
            count_next = count_reg - ONE;
          end else begin
            end_next = 1'b1;
            if (mode_reg) begin
              count_next = reload_reg;
            end else begin
              count_next = '0;
              busy_next  = 1'b0;
            end
          end
        end else begin
          count_next = '0;
        end
      end

      always_ff @(posedge CLK_I) begin
        if (RST_I) begin
          count_reg  <= '0;
          reload_reg <= '0;
          mode_reg   <= 1'b0;
          busy_reg   <= 1'b0;
          end_reg    <= 1'b0;
        end else begin
          count_reg  <= count_next;
          reload_reg <= reload_next;
          mode_reg   <= mode_next;
          busy_reg   <= busy_next;
          end_reg    <= end_next;
        end
      end

      assign end_strobe[gi] = end_reg;
      assign busy[gi]       = busy_reg;
    end
  endgenerate

endmodule
